// File: rtl/pipe_rc_adder_if.sv
// Operand/result handshake bundle for the pipelined ripple-carry adder.
interface pipe_rc_adder_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/pipe_rc_adder.sv
// Pipelined ripple-carry add/sub: one WIDTH/STAGES-bit slice per rank,
// carries registered between slices, stall-on-backpressure handshake.
module pipe_rc_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  pipe_rc_adder_if.slave p
);
  localparam int SW = WIDTH / STAGES;
  localparam int NM = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int L  = STAGES - 1;

  if (WIDTH < 2) begin : g_bad_width
    $error("pipe_rc_adder: WIDTH must be >= 2");
  end
  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_stages
    $error("pipe_rc_adder: STAGES must be >= 1 and divide WIDTH");
  end

  logic [WIDTH-1:0] st_a [STAGES];
  logic [WIDTH-1:0] st_b [STAGES];
  logic [WIDTH-1:0] st_s [STAGES];
  logic [WIDTH-1:0] nx_s [STAGES];
  logic             st_c [STAGES];
  logic             st_v [STAGES];
  logic             nx_c [STAGES];

  logic [WIDTH-1:0] mid_a_q [NM];
  logic [WIDTH-1:0] mid_a_d [NM];
  logic [WIDTH-1:0] mid_b_q [NM];
  logic [WIDTH-1:0] mid_b_d [NM];
  logic [WIDTH-1:0] mid_s_q [NM];
  logic [WIDTH-1:0] mid_s_d [NM];
  logic             mid_c_q [NM];
  logic             mid_c_d [NM];
  logic             mid_v_q [NM];
  logic             mid_v_d [NM];

  logic             val_q, val_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             stall;

  // Stage k input: rank k registers (stage 0 is the raw operand port).
  always_comb begin
    logic cy;
    logic fa_a;
    logic fa_b;
    cy   = 1'b0;
    fa_a = 1'b0;
    fa_b = 1'b0;
    st_a[0] = p.a;
    st_b[0] = p.sub ? ~p.b : p.b;
    st_s[0] = '0;
    st_c[0] = p.sub | p.cin;
    st_v[0] = p.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      st_a[k] = mid_a_q[k-1];
      st_b[k] = mid_b_q[k-1];
      st_s[k] = mid_s_q[k-1];
      st_c[k] = mid_c_q[k-1];
      st_v[k] = mid_v_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      cy      = st_c[k];
      nx_s[k] = st_s[k];
      for (int j = 0; j < SW; j++) begin
        fa_a = st_a[k][k*SW+j];
        fa_b = st_b[k][k*SW+j];
        nx_s[k][k*SW+j] = fa_a ^ fa_b ^ cy;
        cy = (fa_a & fa_b) | (cy & (fa_a ^ fa_b));
      end
      nx_c[k] = cy;
    end
  end

  always_comb begin
    stall   = val_q & ~p.out_ready;
    mid_a_d = mid_a_q;
    mid_b_d = mid_b_q;
    mid_s_d = mid_s_q;
    mid_c_d = mid_c_q;
    mid_v_d = mid_v_q;
    val_d   = val_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    if (!stall) begin
      for (int m = 0; m < STAGES - 1; m++) begin
        mid_a_d[m] = st_a[m];
        mid_b_d[m] = st_b[m];
        mid_s_d[m] = nx_s[m];
        mid_c_d[m] = nx_c[m];
        mid_v_d[m] = st_v[m];
      end
      val_d  = st_v[L];
      sum_d  = nx_s[L];
      cout_d = nx_c[L];
      ovf_d  = (st_a[L][WIDTH-1] == st_b[L][WIDTH-1])
             & (nx_s[L][WIDTH-1] != st_a[L][WIDTH-1]);
      zero_d = ~|nx_s[L];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int m = 0; m < NM; m++) begin
        mid_a_q[m] <= '0;
        mid_b_q[m] <= '0;
        mid_s_q[m] <= '0;
        mid_c_q[m] <= 1'b0;
        mid_v_q[m] <= 1'b0;
      end
      val_q  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      mid_a_q <= mid_a_d;
      mid_b_q <= mid_b_d;
      mid_s_q <= mid_s_d;
      mid_c_q <= mid_c_d;
      mid_v_q <= mid_v_d;
      val_q   <= val_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign p.in_ready  = ~stall;
  assign p.out_valid = val_q;
  assign p.sum       = sum_q;
  assign p.cout      = cout_q;
  assign p.ovf       = ovf_q;
  assign p.zero      = zero_q;
endmodule

// File: doc/pipe_rc_adder.md
PIPE_RC_ADDER -- requirements
Module: pipe_rc_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and sum width; SHALL be >= 2.
REQ-002 Parameter STAGES, default 4: number of pipeline register ranks; SHALL be >= 1, and WIDTH SHALL be divisible by STAGES (elaboration error otherwise).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand set on a/b/cin/sub is valid.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in; used only when sub=0.
REQ-010 sub  input  1  mode: 0 = a+b+cin, 1 = a-b (a + ~b + 1, cin ignored).
REQ-011 out_valid  output  1  result outputs are valid.
REQ-012 out_ready  input  1  downstream accepts result this cycle.
REQ-013 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-014 cout  output  1  carry out of MSB; for sub=1, 1 = no borrow.
REQ-015 ovf  output  1  two's-complement signed overflow.
REQ-016 zero  output  1  sum equals 0.

Function
REQ-017 The datapath SHALL be split into STAGES slices of WIDTH/STAGES bits; each slice SHALL be a ripple chain of full-adder cells whose carry-in is the registered carry-out of the previous slice (slice 0 takes the effective carry-in).
REQ-018 Operand bits of slice k SHALL be delayed by k ranks before use, and sum bits of slice k SHALL be delayed by STAGES-1-k ranks, so that all sum bits of one transaction appear together.
REQ-019 Each rank SHALL carry a valid bit; out_valid SHALL be the valid bit of the last rank.
REQ-020 stall SHALL be out_valid AND NOT out_ready; in_ready SHALL be NOT stall, combinationally.
REQ-021 When not stalled, all ranks SHALL advance one position every cycle; rank 1 SHALL load the new transaction if in_valid=1, otherwise a bubble (valid=0).
REQ-022 When stalled, every rank, including the outputs, SHALL hold its value; inputs SHALL be ignored.
REQ-023 A transaction accepted at edge E SHALL be presented with out_valid=1 from edge E+STAGES-1 onward; throughput SHALL be one transaction per cycle with no stalls.
REQ-024 Results SHALL leave in acceptance order, each exactly once, completing on the cycle where out_valid=1 and out_ready=1.
REQ-025 Bubbles SHALL NOT be collapsed; a bubble occupies its rank until it shifts out.
REQ-026 ovf SHALL be 1 iff effective A MSB equals effective B MSB (B inverted when sub=1) and sum MSB differs from A MSB.
REQ-027 zero SHALL be 1 iff all WIDTH sum bits are 0, independent of cout.
REQ-028 sum/cout/ovf/zero are don't-care while out_valid=0.
REQ-029 With STAGES=1, the block SHALL be a full-width ripple adder feeding one output rank (latency 1 edge).

Reset
REQ-030 While rst_n=0: all valid bits SHALL be 0, and sum, cout, ovf and zero SHALL be 0; in_ready SHALL therefore be 1.
REQ-031 Assertion mid-operation SHALL discard all in-flight transactions immediately, and none SHALL emerge after release.
REQ-032 The first transaction SHALL be acceptable on the first rising edge after rst_n rises.

Verification (WIDTH=32, STAGES=4)
REQ-033 Reset released, no stimulus -> out_valid=0, sum=0x00000000, cout=0, ovf=0, zero=0, in_ready=1.
REQ-034 a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 accepted at edge 1 -> from edge 4: out_valid=1, sum=0x00000000, cout=1, ovf=0, zero=1.
REQ-035 a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, cout=0, ovf=1, zero=0. Then a=0x00000005, b=0x00000007, sub=1, cin=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
REQ-036 Eight back-to-back transactions (a=i, b=i, i=1..8), out_ready=0 during cycles 6-8 -> in_ready=0 exactly in those cycles, results 2,4,...,16 in order, none lost or duplicated.
REQ-037 in_valid toggling 1,0,1,0 -> out_valid pattern 1,0,1,0 with the bubbles preserved, starting 3 edges after the first acceptance.
REQ-038 rst_n pulsed low with 3 transactions in flight -> out_valid=0 asynchronously, and no result appears in the 10 cycles after release.
